note_lane_renderer: RTL and testbench
=====================================

Name: note_lane_renderer

Overview:
- Downstream of the pattern/command stage; upstream of the vga controller.
- Holds up to N_SLOTS falling notes, each a 4-bit lane command accepted through a valid/ready handshake.
- Advances every note once per frame during vertical blank.
- Returns RGB for the pixel the vga block requests via next_x/next_y, so top level wires R/G/B directly instead of the per-command colour mux.

Parameters:
- N_SLOTS, 8, number of concurrent note slots
- LANE_X0, 160, x of left edge of lane 0
- LANE_W, 80, lane width in pixels; lanes 0..3 contiguous
- NOTE_H, 16, note height in pixels
- SPEED, 2, pixels a note falls per frame
- H_ACTIVE, 640, visible width
- V_ACTIVE, 480, visible height
- HIT_Y, 440, first row of the 2-row hit line

Ports:
- CLOCK_25  in  1  pixel clock, all logic rising edge
- reset  in  1  synchronous, active-high
- spawn_valid  in  1  new note offered
- spawn_lanes  in  4  command bits; bit L = note in lane L
- spawn_ready  out  1  note accepted when valid&&ready
- next_x  in  10  pixel column requested by vga
- next_y  in  10  pixel row requested by vga
- R_out  out  8  red for (next_x,next_y), 1-cycle latency
- G_out  out  8  green, same timing
- B_out  out  8  blue, same timing
- miss_pulse  out  1  one cycle per note falling off screen
- active_count  out  4  number of occupied slots

Behaviour:
- Reset: all slots invalid, state IDLE, R/G/B_out=0, miss_pulse=0, active_count=0, spawn_ready=0 while reset high.
- Slot contents: valid, lanes[3:0], y[9:0] (top row of note).
- frame_start = (next_x==0 && next_y==V_ACTIVE). This is a single cycle per frame.
- States:
  - IDLE -> UPDATE on frame_start.
  - UPDATE: index i steps 0..N_SLOTS-1, one slot per cycle. On i==N_SLOTS-1 return to IDLE. UPDATE therefore lasts exactly N_SLOTS cycles.
- UPDATE per slot, only if valid:
  - y_new = y + SPEED, computed at 11 bits.
  - If y_new >= V_ACTIVE: clear valid and pulse miss_pulse that cycle.
  - Otherwise y <= y_new.
- spawn_ready = (state==IDLE) && !frame_start && (a free slot exists).
- On handshake:
  - Lowest-index free slot takes lanes=spawn_lanes, y=0, valid=1.
  - spawn_lanes==0 is accepted but consumes no slot.
- spawn_valid while not ready: the producer holds the value; nothing is dropped inside the block.
- active_count is registered and reflects spawns and expiries the cycle after they occur.
- Render (combinational hit test, registered output, latency exactly 1 cycle):
  - A pixel is in lane L if LANE_X0+L*LANE_W <= x < LANE_X0+(L+1)*LANE_W.
  - Note hit: some valid slot has lanes[L]=1 and y <= next_y < y+NOTE_H.
  - Lane colours:
    - lane0: R=FF
    - lane1: G=FF
    - lane2: B=FF
    - lane3: G=FF, B=FF
  - Multiple slots hitting one pixel: colours OR together.
  - Priority: note > hit line (next_y in HIT_Y..HIT_Y+1 and pixel inside any lane: FF,FF,FF) > black.
  - next_x >= H_ACTIVE or next_y >= V_ACTIVE: output 0.
  - Notes near the bottom clip naturally at V_ACTIVE.
- Reset asserted mid-UPDATE: return to IDLE and clear all slots next edge. No miss_pulse is emitted.

Decomposition:
- Shared package note_pkg holds:
  - lane colour constants
  - state enum {IDLE, UPDATE}
  - slot record typedef (valid, lanes, y)
  - default geometry constants, also reused by the pattern stage
- One sub-module: note_hit_test.
  - Combinational.
  - Inputs: one slot, next_x, next_y.
  - Output: 4-bit lane hit vector.
  - Instantiated N_SLOTS times; outputs are OR-reduced.

Test Plan:
- Reset then idle, request pixel (250,3) -> RGB 000000 one cycle later; spawn_ready=1, active_count=0.
- Spawn 4'b0010, one frame_start, wait 8 cycles, request (250,3) -> G_out=FF, R=B=0. Request (250,18) -> 000000 (note spans y 2..17).
- Spawn 4'b1001, run frames, request (170,HIT_Y) once the note covers it -> R=FF,G=00,B=00. Request (170,HIT_Y) before the note arrives -> FFFFFF.
- Spawn 8 notes back-to-back -> spawn_ready low after the 8th handshake, active_count=8. A 9th spawn_valid is held with no acceptance.
- Assert spawn_valid during the frame_start cycle -> not accepted that cycle, accepted the first IDLE cycle after UPDATE.
- Single note, 240 frames -> miss_pulse exactly once, in the 240th UPDATE. active_count 1->0, slot reusable.

Source files
------------

// File: rtl/note_pkg.sv
// note_pkg: shared types and constants for the falling-note lane renderer.
// Holds the default screen/lane geometry (also used by the pattern stage),
// the per-lane colours, the renderer FSM state enum and the note slot record.
package note_pkg;

  // Default geometry
  localparam int DEF_N_SLOTS  = 8;
  localparam int DEF_LANE_X0  = 160;
  localparam int DEF_LANE_W   = 80;
  localparam int DEF_NOTE_H   = 16;
  localparam int DEF_SPEED    = 2;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_HIT_Y    = 440;
  localparam int N_LANES      = 4;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Lane colours; overlapping notes OR these together
  localparam rgb_t COL_LANE0   = '{r: 8'hFF, g: 8'h00, b: 8'h00};
  localparam rgb_t COL_LANE1   = '{r: 8'h00, g: 8'hFF, b: 8'h00};
  localparam rgb_t COL_LANE2   = '{r: 8'h00, g: 8'h00, b: 8'hFF};
  localparam rgb_t COL_LANE3   = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
  localparam rgb_t COL_HITLINE = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};

  typedef enum logic {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } state_t;

  // One falling note: y is the top row of the note
  typedef struct packed {
    logic       valid;
    logic [3:0] lanes;
    logic [9:0] y;
  } slot_t;

endpackage

// File: rtl/note_hit_test.sv
// note_hit_test: combinational hit test of one note slot against a pixel.
// Ports:
//   slot          - note record (valid, lanes, y)
//   next_x/next_y - pixel being rendered
//   hit[3:0]      - bit L set when the pixel lies on this note in lane L
module note_hit_test
  import note_pkg::*;
#(
  parameter int LANE_X0 = DEF_LANE_X0,
  parameter int LANE_W  = DEF_LANE_W,
  parameter int NOTE_H  = DEF_NOTE_H
) (
  input  slot_t       slot,
  input  logic [9:0]  next_x,
  input  logic [9:0]  next_y,
  output logic [3:0]  hit
);

  logic [10:0] y_end;
  logic        in_rows;

  always_comb begin
    // 11-bit sum so a note near the bottom does not wrap
    y_end   = {1'b0, slot.y} + 11'(NOTE_H);
    in_rows = slot.valid && (next_y >= slot.y) && ({1'b0, next_y} < y_end);
    hit     = '0;
    for (int l = 0; l < N_LANES; l++) begin
      hit[l] = in_rows && slot.lanes[l]
               && ({1'b0, next_x} >= 11'(LANE_X0 + l * LANE_W))
               && ({1'b0, next_x} <  11'(LANE_X0 + (l + 1) * LANE_W));
    end
  end

endmodule

// File: rtl/note_lane_renderer.sv
// note_lane_renderer: holds up to N_SLOTS falling notes, moves them down once
// per frame during vertical blank and renders RGB for the pixel the VGA
// controller requests.
// Ports:
//   CLOCK_25                 - pixel clock, rising edge
//   reset                    - synchronous, active-high
//   spawn_valid/spawn_lanes/spawn_ready - new-note handshake
//   next_x/next_y            - pixel requested by the VGA controller
//   R_out/G_out/B_out        - colour for that pixel, one cycle later
//   miss_pulse               - one cycle per note leaving the screen
//   active_count             - number of occupied slots
//
// Handshake: a note is transferred on a rising edge where spawn_valid and
// spawn_ready are both high. The producer must hold spawn_lanes stable while
// spawn_valid is high and ready is low; spawn_ready never depends on
// spawn_valid. A transfer with spawn_lanes==0 completes but stores nothing.
module note_lane_renderer
  import note_pkg::*;
#(
  parameter int N_SLOTS  = DEF_N_SLOTS,
  parameter int LANE_X0  = DEF_LANE_X0,
  parameter int LANE_W   = DEF_LANE_W,
  parameter int NOTE_H   = DEF_NOTE_H,
  parameter int SPEED    = DEF_SPEED,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int HIT_Y    = DEF_HIT_Y
) (
  input  logic       CLOCK_25,
  input  logic       reset,
  input  logic       spawn_valid,
  input  logic [3:0] spawn_lanes,
  output logic       spawn_ready,
  input  logic [9:0] next_x,
  input  logic [9:0] next_y,
  output logic [7:0] R_out,
  output logic [7:0] G_out,
  output logic [7:0] B_out,
  output logic       miss_pulse,
  output logic [3:0] active_count
);

  localparam int IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  state_t           state;
  logic [IDX_W-1:0] idx;
  slot_t            slots [N_SLOTS];
  rgb_t             pix_q;

  logic             frame_start;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             accept;
  logic [10:0]      y_new;
  logic             expire;
  logic [3:0]       hits [N_SLOTS];
  logic [3:0]       lane_hit;
  logic             in_lanes;
  logic             on_line;
  rgb_t             pix;

  assign frame_start = (next_x == 10'd0) && (next_y == 10'(V_ACTIVE));

  // Lowest-index free slot: scan downward so the smallest index wins
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!slots[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign spawn_ready = !reset && (state == IDLE) && !frame_start && free_found;
  assign accept      = spawn_valid && spawn_ready;

  // Fall step for the slot currently being visited in UPDATE
  assign y_new  = {1'b0, slots[idx].y} + 11'(SPEED);
  assign expire = y_new >= 11'(V_ACTIVE);

  for (genvar s = 0; s < N_SLOTS; s++) begin : g_hit
    note_hit_test #(
      .LANE_X0 (LANE_X0),
      .LANE_W  (LANE_W),
      .NOTE_H  (NOTE_H)
    ) u_hit (
      .slot   (slots[s]),
      .next_x (next_x),
      .next_y (next_y),
      .hit    (hits[s])
    );
  end

  // Pixel colour: notes win over the hit line, which wins over black
  always_comb begin
    lane_hit = '0;
    for (int i = 0; i < N_SLOTS; i++) lane_hit = lane_hit | hits[i];
    in_lanes = (next_x >= 10'(LANE_X0))
               && ({1'b0, next_x} < 11'(LANE_X0 + N_LANES * LANE_W));
    on_line  = (next_y == 10'(HIT_Y)) || (next_y == 10'(HIT_Y + 1));
    pix      = '0;
    if ((next_x < 10'(H_ACTIVE)) && (next_y < 10'(V_ACTIVE))) begin
      if (|lane_hit) begin
        if (lane_hit[0]) pix = rgb_t'(pix | COL_LANE0);
        if (lane_hit[1]) pix = rgb_t'(pix | COL_LANE1);
        if (lane_hit[2]) pix = rgb_t'(pix | COL_LANE2);
        if (lane_hit[3]) pix = rgb_t'(pix | COL_LANE3);
      end else if (in_lanes && on_line) begin
        pix = COL_HITLINE;
      end
    end
  end

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      miss_pulse   <= 1'b0;
      active_count <= '0;
      pix_q        <= '0;
      for (int i = 0; i < N_SLOTS; i++) slots[i] <= '0;
    end else begin
      miss_pulse <= 1'b0;
      pix_q      <= pix;
      case (state)
        IDLE: begin
          if (frame_start) begin
            state <= UPDATE;
            idx   <= '0;
          end else if (accept && (spawn_lanes != 4'd0)) begin
            slots[free_idx] <= '{valid: 1'b1, lanes: spawn_lanes, y: 10'd0};
            active_count    <= active_count + 4'd1;
          end
        end
        UPDATE: begin
          if (slots[idx].valid) begin
            if (expire) begin
              slots[idx].valid <= 1'b0;
              miss_pulse       <= 1'b1;
              active_count     <= active_count - 4'd1;
            end else begin
              slots[idx].y <= y_new[9:0];
            end
          end
          if (idx == IDX_W'(N_SLOTS - 1)) state <= IDLE;
          else                            idx   <= idx + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign R_out = pix_q.r;
  assign G_out = pix_q.g;
  assign B_out = pix_q.b;

endmodule

// File: tb/tb_note_lane_renderer.sv
// tb_note_lane_renderer: directed bench for note_lane_renderer. Inputs are
// driven on the falling edge; outputs are checked on a later falling edge.
module tb_note_lane_renderer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       spawn_valid = 1'b0;
  logic [3:0] spawn_lanes = 4'd0;
  logic       spawn_ready;
  logic [9:0] next_x = 10'd1;
  logic [9:0] next_y = 10'd1;
  logic [7:0] R_out, G_out, B_out;
  logic       miss_pulse;
  logic [3:0] active_count;

  int vec_count = 0;
  int err_count = 0;
  int frame_no  = 0;
  int miss_count = 0;
  int last_miss_frame = -1;

  // Clock / reset block
  always #20 clk = ~clk;

  note_lane_renderer dut (
    .CLOCK_25     (clk),
    .reset        (reset),
    .spawn_valid  (spawn_valid),
    .spawn_lanes  (spawn_lanes),
    .spawn_ready  (spawn_ready),
    .next_x       (next_x),
    .next_y       (next_y),
    .R_out        (R_out),
    .G_out        (G_out),
    .B_out        (B_out),
    .miss_pulse   (miss_pulse),
    .active_count (active_count)
  );

  always @(negedge clk) begin
    if (miss_pulse) begin
      miss_count      <= miss_count + 1;
      last_miss_frame <= frame_no;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; spawn_valid = 1'b0; spawn_lanes = 4'd0;
    next_x = 10'd1; next_y = 10'd1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic request(input int x, input int y, input logic [23:0] exp, input string name);
    @(negedge clk);
    next_x = 10'(x); next_y = 10'(y);
    @(negedge clk);
    vec_count++;
    if ({R_out, G_out, B_out} !== exp) begin
      err_count++;
      $display("FAIL %s pixel(%0d,%0d): got %06h, expected %06h", name, x, y, {R_out, G_out, B_out}, exp);
    end
  endtask

  task automatic spawn(input logic [3:0] lanes, input string name);
    @(negedge clk);
    spawn_valid = 1'b1; spawn_lanes = lanes;
    #1;
    vec_count++;
    if (spawn_ready !== 1'b1) begin
      err_count++;
      $display("FAIL %s spawn_ready: got %b, expected 1", name, spawn_ready);
    end
    @(negedge clk);
    spawn_valid = 1'b0;
  endtask

  task automatic run_frame();
    frame_no++;
    @(negedge clk);
    next_x = 10'd0; next_y = 10'd480;
    @(negedge clk);
    next_x = 10'd1; next_y = 10'd1;
    repeat (8) @(negedge clk);
  endtask

  task automatic check_count(input logic [3:0] exp, input string name);
    vec_count++;
    if (active_count !== exp) begin
      err_count++;
      $display("FAIL %s active_count: got %0d, expected %0d", name, active_count, exp);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; spawn_valid = 1'b1; spawn_lanes = 4'b0001;
    next_x = 10'd250; next_y = 10'd3;
    @(negedge clk);
    vec_count++;
    if ({R_out, G_out, B_out, miss_pulse, active_count, spawn_ready} !== 30'd0) begin
      err_count++;
      $display("FAIL reset_outputs: got rgb=%06h miss=%b cnt=%0d ready=%b, expected all 0",
               {R_out, G_out, B_out}, miss_pulse, active_count, spawn_ready);
    end
    reset = 1'b0; spawn_valid = 1'b0;
    #1;
    vec_count++;
    if (spawn_ready !== 1'b1) begin
      err_count++;
      $display("FAIL reset_ready: got %b, expected 1", spawn_ready);
    end
    request(250, 3, 24'h000000, "idle_black");
    check_count(4'd0, "reset_count");
  endtask

  task automatic test_single_note();
    do_reset();
    spawn(4'b0010, "single");
    run_frame();
    request(250, 3,  24'h00FF00, "lane1_row3");
    request(250, 2,  24'h00FF00, "lane1_top");
    request(250, 18, 24'h000000, "lane1_below");
    request(640, 3,  24'h000000, "off_right");
    check_count(4'd1, "single_count");
  endtask

  task automatic test_hit_line();
    do_reset();
    spawn(4'b1001, "hitline");
    request(170, 440, 24'hFFFFFF, "line_row0");
    request(170, 441, 24'hFFFFFF, "line_row1");
    request(150, 440, 24'h000000, "line_outside");
    repeat (213) run_frame();
    request(170, 440, 24'hFF0000, "note_over_line");
    request(420, 440, 24'h00FFFF, "lane3_over_line");
    request(250, 440, 24'hFFFFFF, "line_lane1");
    request(170, 425, 24'h000000, "above_note");
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    spawn_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      spawn_lanes = 4'(1 << (k % 4));
      #1;
      vec_count++;
      if (spawn_ready !== 1'b1) begin
        err_count++;
        $display("FAIL b2b_ready[%0d]: got %b, expected 1", k, spawn_ready);
      end
      @(negedge clk);
    end
    spawn_lanes = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1;
      vec_count++;
      if (spawn_ready !== 1'b0 || active_count !== 4'd8) begin
        err_count++;
        $display("FAIL b2b_full[%0d]: got ready=%b cnt=%0d, expected ready=0 cnt=8", k, spawn_ready, active_count);
      end
      @(negedge clk);
    end
    spawn_valid = 1'b0;
    request(170, 5, 24'hFF0000, "b2b_lane0");
    request(420, 5, 24'h00FFFF, "b2b_lane3");
  endtask

  task automatic test_spawn_at_frame_start();
    int n;
    do_reset();
    @(negedge clk);
    next_x = 10'd0; next_y = 10'd480;
    spawn_valid = 1'b1; spawn_lanes = 4'b0100;
    #1;
    vec_count++;
    if (spawn_ready !== 1'b0) begin
      err_count++;
      $display("FAIL fs_ready: got %b, expected 0", spawn_ready);
    end
    @(negedge clk);
    next_x = 10'd0; next_y = 10'd0;
    #1;
    n = 1;
    while (!spawn_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    vec_count++;
    if (n != 9) begin
      err_count++;
      $display("FAIL fs_accept_cycle: got ready at cycle %0d, expected 9", n);
    end
    check_count(4'd0, "fs_count_before");
    @(negedge clk);
    spawn_valid = 1'b0;
    #1;
    check_count(4'd1, "fs_count_after");
    request(330, 0, 24'h0000FF, "fs_lane2");
  endtask

  task automatic test_reset_mid_update();
    int base;
    do_reset();
    spawn(4'b0001, "mid");
    repeat (239) run_frame();
    check_count(4'd1, "mid_count_before");
    base = miss_count;
    @(negedge clk);
    next_x = 10'd0; next_y = 10'd480;
    @(negedge clk);
    next_x = 10'd1; next_y = 10'd1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    vec_count++;
    if (miss_count != base) begin
      err_count++;
      $display("FAIL mid_no_miss: got %0d pulses, expected 0", miss_count - base);
    end
    check_count(4'd0, "mid_count_after");
    request(170, 479, 24'h000000, "mid_cleared");
  endtask

  task automatic test_miss();
    int base;
    do_reset();
    spawn(4'b0001, "miss");
    base = miss_count;
    frame_no = 0;
    repeat (239) run_frame();
    vec_count++;
    if (miss_count != base) begin
      err_count++;
      $display("FAIL miss_early: got %0d pulses, expected 0", miss_count - base);
    end
    check_count(4'd1, "miss_count_239");
    request(170, 479, 24'hFF0000, "miss_clip_bottom");
    run_frame();
    vec_count++;
    if (miss_count - base != 1 || last_miss_frame != 240) begin
      err_count++;
      $display("FAIL miss_once: got %0d pulses last frame %0d, expected 1 in frame 240",
               miss_count - base, last_miss_frame);
    end
    check_count(4'd0, "miss_count_240");
    spawn(4'b0010, "reuse");
    check_count(4'd1, "reuse_count");
    request(250, 0, 24'h00FF00, "reuse_pixel");
    spawn(4'b0000, "empty");
    check_count(4'd1, "empty_count");
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_hit_line();
    test_back_to_back();
    test_spawn_at_frame_start();
    test_reset_mid_update();
    test_miss();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
